// File: rtl/goldschmidt_round.sv
// Result back-end for the Goldschmidt div/sqrt datapath: remainder correction, rounding, valid/ready output.
// Optional sticky inexact flag enabled by defining GOLDSCHMIDT_ROUND_INEXACT_EN.
//
// state   | meaning
// IDLE    | waiting for a raw quotient (in_ready=1)
// CORRECT | apply q-1 for a negative division remainder
// ROUND   | round to OUT_WIDTH bits, register result/flags
// OUT     | present result until downstream accepts (out_valid=1)
module goldschmidt_round #(
    parameter int WIDTH     = 30,
    parameter int OUT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     quotient,
    input  logic                 rem_sign,
    input  logic [1:0]           op,
    input  logic [1:0]           rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 inexact,
    output logic                 overflow
);

    localparam int G = WIDTH - OUT_WIDTH;

    generate
        if (G < 2) begin : g_width_check
            $error("goldschmidt_round: WIDTH-OUT_WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORRECT = 2'd1,
        ROUND   = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]     q_reg;
    logic                 rem_sign_reg;
    logic [1:0]           op_reg;
    logic [1:0]           rm_reg;
    logic [OUT_WIDTH-1:0] result_reg;
    logic                 overflow_reg;

    logic [OUT_WIDTH-1:0] trunc;
    logic                 guard_bit;
    logic                 sticky_bit;
    logic                 round_inc;
    logic [OUT_WIDTH:0]   sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CORRECT;
            CORRECT: state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    // Correction saturates at zero so a zero quotient never wraps to all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg        <= '0;
            rem_sign_reg <= 1'b0;
            op_reg       <= 2'b00;
            rm_reg       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg        <= quotient;
                        rem_sign_reg <= rem_sign;
                        op_reg       <= op;
                        rm_reg       <= rm;
                    end
                end
                CORRECT: begin
                    if ((op_reg == 2'b00) && rem_sign_reg && (q_reg != '0)) begin
                        q_reg <= q_reg - WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        trunc      = q_reg[WIDTH-1:G];
        guard_bit  = q_reg[G-1];
        sticky_bit = |q_reg[G-2:0];
        round_inc  = 1'b0;
        case (rm_reg)
            2'b01:   round_inc = 1'b0;
            2'b10:   round_inc = guard_bit | sticky_bit;
            default: round_inc = guard_bit & (sticky_bit | trunc[0]);
        endcase
        sum = {1'b0, trunc} + {{OUT_WIDTH{1'b0}}, round_inc};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (state == ROUND) begin
            if (sum[OUT_WIDTH]) begin
                result_reg   <= '1;
                overflow_reg <= 1'b1;
            end else begin
                result_reg   <= sum[OUT_WIDTH-1:0];
                overflow_reg <= 1'b0;
            end
        end
    end

    assign result   = result_reg;
    assign overflow = overflow_reg;

`ifdef GOLDSCHMIDT_ROUND_INEXACT_EN
    logic inexact_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inexact_reg <= 1'b0;
        end else if (state == ROUND) begin
            inexact_reg <= guard_bit | sticky_bit;
        end
    end

    assign inexact = inexact_reg;
`else
    assign inexact = 1'b0;
`endif

endmodule

// File: tb/tb_goldschmidt_round.sv
// Scoreboard bench for goldschmidt_round: directed vectors, queue of expected results, negedge monitor.
module tb_goldschmidt_round;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] quotient;
    logic        rem_sign;
    logic [1:0]  op;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic        inexact;
    logic        overflow;

`ifdef GOLDSCHMIDT_ROUND_INEXACT_EN
    localparam bit INX_EN = 1'b1;
`else
    localparam bit INX_EN = 1'b0;
`endif

    typedef struct {
        logic [23:0] result;
        logic        inexact;
        logic        overflow;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    goldschmidt_round #(.WIDTH(30), .OUT_WIDTH(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .quotient (quotient),
        .rem_sign (rem_sign),
        .op       (op),
        .rm       (rm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .inexact  (inexact),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares presented output to the queue head; pops on handshake.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %0h with no expected entry", result);
            end else begin
                chk("sb_result", {8'h0, result}, {8'h0, sb[0].result});
                chk("sb_inexact", {31'h0, inexact}, {31'h0, sb[0].inexact});
                chk("sb_overflow", {31'h0, overflow}, {31'h0, sb[0].overflow});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic issue(input logic [29:0] q, input logic rs, input logic [1:0] o,
                         input logic [1:0] r);
        quotient = q;
        rem_sign = rs;
        op       = o;
        rm       = r;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [23:0] er, input logic ei, input logic eo);
        exp_t e;
        e.result   = er;
        e.inexact  = INX_EN ? ei : 1'b0;
        e.overflow = eo;
        sb.push_back(e);
    endtask

    // Full operation with out_ready high: checks accept, latency of 3 edges and drain.
    task automatic run_op(input logic [29:0] q, input logic rs, input logic [1:0] o,
                          input logic [1:0] r, input logic [23:0] er, input logic ei,
                          input logic eo);
        int lat;
        wait_ready();
        push_exp(er, ei, eo);
        issue(q, rs, o, r);
        chk("accept_in_ready", {31'h0, in_ready}, 32'h0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 32'd3);
        @(posedge clk); #1;
        chk("drain_out_valid", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        rem_sign  = 1'b0;
        op        = 2'b00;
        rm        = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", {8'h0, result}, 32'h0);
        chk("rst_inexact", {31'h0, inexact}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Exact sqrt, RNE ties to even, odd tie rounds up
        run_op(30'h20000000, 1'b0, 2'b01, 2'b00, 24'h800000, 1'b0, 1'b0);
        run_op(30'h20000020, 1'b0, 2'b01, 2'b00, 24'h800000, 1'b1, 1'b0);
        run_op(30'h20000060, 1'b0, 2'b01, 2'b00, 24'h800002, 1'b1, 1'b0);
        // Division correction to 0x2000003F under each rounding mode
        run_op(30'h20000040, 1'b1, 2'b00, 2'b00, 24'h800001, 1'b1, 1'b0);
        run_op(30'h20000040, 1'b1, 2'b00, 2'b01, 24'h800000, 1'b1, 1'b0);
        run_op(30'h20000040, 1'b1, 2'b00, 2'b10, 24'h800001, 1'b1, 1'b0);
        run_op(30'h20000040, 1'b1, 2'b00, 2'b11, 24'h800001, 1'b1, 1'b0);
        // rem_sign ignored for sqrt: 0x20000040 exact
        run_op(30'h20000040, 1'b1, 2'b10, 2'b10, 24'h800001, 1'b0, 1'b0);
        // No wrap at zero, overflow saturation, RU with sticky only, RZ no overflow
        run_op(30'h00000000, 1'b1, 2'b00, 2'b00, 24'h000000, 1'b0, 1'b0);
        run_op(30'h3FFFFFFF, 1'b0, 2'b01, 2'b00, 24'hFFFFFF, 1'b1, 1'b1);
        run_op(30'h3FFFFFC1, 1'b0, 2'b01, 2'b10, 24'hFFFFFF, 1'b1, 1'b1);
        run_op(30'h3FFFFFFF, 1'b0, 2'b01, 2'b01, 24'hFFFFFF, 1'b1, 1'b0);
        run_op(30'h00000001, 1'b0, 2'b01, 2'b10, 24'h000001, 1'b1, 1'b0);

        // Backpressure: held result, new quotient ignored
        out_ready = 1'b0;
        wait_ready();
        push_exp(24'h800002, 1'b1, 1'b0);
        issue(30'h20000060, 1'b0, 2'b01, 2'b00);
        in_valid = 1'b1;
        quotient = 30'h3FFFFFFF;
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_out_valid", {31'h0, out_valid}, 32'h0);
        chk("stall_release_in_ready", {31'h0, in_ready}, 32'h1);
        chk("held_after_hs", {8'h0, result}, 32'h800002);
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale_capture", {31'h0, in_ready}, 32'h1);
        run_op(30'h20000000, 1'b0, 2'b01, 2'b00, 24'h800000, 1'b0, 1'b0);

        // Reset during CORRECT, ROUND and OUT
        for (int k = 1; k <= 3; k++) begin
            out_ready = 1'b0;
            wait_ready();
            issue(30'h3FFFFFFF, 1'b0, 2'b01, 2'b00);
            repeat (k - 1) begin
                @(posedge clk); #1;
            end
            reset = 1'b1;
            #1;
            chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
            chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
            chk("midrst_result", {8'h0, result}, 32'h0);
            chk("midrst_overflow", {31'h0, overflow}, 32'h0);
            #2;
            reset     = 1'b0;
            out_ready = 1'b1;
            run_op(30'h20000040, 1'b1, 2'b00, 2'b00, 24'h800001, 1'b1, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
